// File: rtl/aes_input_loader.sv
// aes_input_loader: assembles a 16-byte plaintext and a 16-byte key from a byte stream for an AES core.
module aes_input_loader #(
  parameter bit KEY_REUSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] pt_out,
  output logic [127:0] key_out,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam logic [1:0] LOAD_PT  = 2'd0;
  localparam logic [1:0] LOAD_KEY = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic       key_held;
  logic [6:0] pos;
  assign in_ready  = state != HOLD;
  assign out_valid = state == HOLD;
  // byte n lands at bit 8*(15-n), so byte 0 is the MSB
  assign pos = {~cnt, 3'b000};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_PT;
      cnt      <= 4'd0;
      key_held <= 1'b0;
      pt_out   <= '0;
      key_out  <= '0;
    end else if (clear) begin
      state    <= LOAD_PT;
      cnt      <= 4'd0;
      key_held <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) state <= LOAD_PT;
    end else if (in_valid) begin
      cnt <= cnt + 4'd1;
      if (state == LOAD_PT) pt_out[pos +: 8] <= in_data;
      else key_out[pos +: 8] <= in_data;
      if (cnt == 4'd15) begin
        if (state == LOAD_PT) state <= key_held ? HOLD : LOAD_KEY;
        else begin
          state    <= HOLD;
          key_held <= KEY_REUSE;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_input_loader.sv
// tb_aes_input_loader: directed checks of aes_input_loader with KEY_REUSE=0 (a) and KEY_REUSE=1 (b) sharing inputs.
module tb_aes_input_loader;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [127:0] pt_a, key_a, pt_b, key_b;
  int checks = 0, errors = 0;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT2 = 128'hffeeddccbbaa99887766554433221100;
  always #5 clk = ~clk;
  aes_input_loader #(.KEY_REUSE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .pt_out(pt_a), .key_out(key_a), .out_valid(out_valid_a), .out_ready(out_ready)
  );
  aes_input_loader #(.KEY_REUSE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .pt_out(pt_b), .key_out(key_b), .out_valid(out_valid_b), .out_ready(out_ready)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
  endtask
  function automatic logic [7:0] byte_of(input logic [127:0] v, input int n);
    return v[8*(15-n) +: 8];
  endfunction
  function automatic logic [7:0] frame_byte(input int i);
    return i < 16 ? byte_of(PT, i) : byte_of(KEY, i - 16);
  endfunction
  initial begin
    in_valid = 1'b1;
    in_data  = 8'haa;
    repeat (2) tick();
    chk("rst_pt", pt_a, 0);
    chk("rst_key", key_a, 0);
    chk("rst_ov", out_valid_a, 0);
    chk("rst_ir", in_ready_a, 1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      send(frame_byte(i));
      if (i == 15) begin
        chk("mid_ov", out_valid_a, 0);
        chk("mid_ir", in_ready_a, 1);
      end
    end
    chk("fips_ov", out_valid_a, 1);
    chk("fips_ir", in_ready_a, 0);
    chk("fips_pt", pt_a, PT);
    chk("fips_key", key_a, KEY);
    chk("fips_key_b", key_b, KEY);
    in_data = 8'h5a;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_ov", out_valid_a, 1);
      chk("bp_ir", in_ready_a, 0);
      chk("bp_pt", pt_a, PT);
    end
    chk("bp_key", key_a, KEY);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_ov", out_valid_a, 0);
    chk("hs_ir", in_ready_a, 1);
    chk("hs_pt", pt_a, PT);
    for (int i = 0; i < 16; i++) send(byte_of(PT2, i));
    chk("reuse_ov", out_valid_b, 1);
    chk("reuse_pt", pt_b, PT2);
    chk("reuse_key", key_b, KEY);
    chk("noreuse_ov", out_valid_a, 0);
    chk("noreuse_ir", in_ready_a, 1);
    clear   = 1'b1;
    in_data = 8'h77;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_ov_b", out_valid_b, 0);
    chk("clr_ir_b", in_ready_b, 1);
    chk("clr_pt_b", pt_b, PT2);
    chk("clr_key_b", key_b, KEY);
    chk("clr_key_a", key_a, KEY);
    for (int i = 0; i < 20; i++) send(8'ha0 + 8'(i));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send(frame_byte(i));
      if (i == 15) chk("reload_ov_b", out_valid_b, 0);
    end
    chk("clrf_ov", out_valid_a, 1);
    chk("clrf_pt", pt_a, PT);
    chk("clrf_key", key_a, KEY);
    chk("clrf_ov_b", out_valid_b, 1);
    chk("clrf_key_b", key_b, KEY);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(byte_of(PT2, i));
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pt", pt_a, 0);
    chk("arst_key", key_a, 0);
    chk("arst_ov", out_valid_a, 0);
    chk("arst_pt_b", pt_b, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send(frame_byte(i));
      in_valid = 1'b0;
      if (i == 31) begin
        chk("gap_ov", out_valid_a, 1);
        chk("gap_pt", pt_a, PT);
        chk("gap_key", key_a, KEY);
        chk("gap_key_b", key_b, KEY);
      end
      tick();
      if (i == 30) chk("gap_early_ov", out_valid_a, 0);
    end
    out_ready = 1'b0;
    chk("gap_hs_ov", out_valid_a, 0);
    chk("gap_hs_ir", in_ready_a, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
